// File: rtl/char_proj_pkg.sv
// Shared types and constants for the character-window column projector.
// The optional totals feature is enabled by defining CHAR_PROJ_TOTAL_EN.
package char_proj_pkg;

    localparam int DEF_WIN_W     = 200;
    localparam int DEF_WIN_H     = 105;
    localparam int DEF_BASE_ADDR = 9001;

    localparam int ADDR_W = 16;
    localparam int PIX_W  = 8;
    localparam int COL_W  = 8;
    localparam int CNT_W  = 7;
    localparam int TOT_W  = 15;

    localparam logic [PIX_W-1:0] DEF_THRESH = 8'd128;

    // Sentinel for "no nonzero column seen"; unreachable as a real index.
    localparam logic [COL_W-1:0] NO_COL = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SCAN,
        FLUSH,
        DONE
    } state_t;

    function automatic logic [CNT_W-1:0] sat_add1(input logic [CNT_W-1:0] v,
                                                  input logic             inc);
        if (inc && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/char_column_projector_if.sv
// Pixel-RAM read port and per-column result stream of the column projector.
// The optional totals feature is enabled by defining CHAR_PROJ_TOTAL_EN.
interface char_column_projector_if;
    import char_proj_pkg::*;

    // Handshake: no backpressure anywhere. ram_rdata is valid exactly one
    // cycle after ram_re/ram_addr; col_valid is a one-cycle strobe that the
    // consumer must take in that cycle (col_idx/col_count valid with it).
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_re;
    logic [PIX_W-1:0]  ram_rdata;
    logic              col_valid;
    logic [COL_W-1:0]  col_idx;
    logic [CNT_W-1:0]  col_count;

    modport master (
        output ram_addr,
        output ram_re,
        input  ram_rdata,
        output col_valid,
        output col_idx,
        output col_count
    );

    modport slave (
        input  ram_addr,
        input  ram_re,
        output ram_rdata,
        input  col_valid,
        input  col_idx,
        input  col_count
    );

endinterface

// File: rtl/char_proj_addr_walk.sv
// Column-major address walker over the character window, with row/column tags.
// The optional totals feature is enabled by defining CHAR_PROJ_TOTAL_EN.
module char_proj_addr_walk
    import char_proj_pkg::*;
#(
    parameter int WIN_W     = DEF_WIN_W,
    parameter int WIN_H     = DEF_WIN_H,
    parameter int BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic [COL_W-1:0]  col,
    output logic              row_first,
    output logic              row_last,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] col_base_q;
    logic [CNT_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;

    // col_base_q remembers the top-of-column address so the next column
    // starts one pixel to the right without any multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            col_base_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else if (start) begin
            addr_q     <= ADDR_W'(BASE_ADDR);
            col_base_q <= ADDR_W'(BASE_ADDR);
            row_q      <= '0;
            col_q      <= '0;
        end else if (advance) begin
            if (row_last) begin
                row_q      <= '0;
                col_q      <= col_q + COL_W'(1);
                col_base_q <= col_base_q + ADDR_W'(1);
                addr_q     <= col_base_q + ADDR_W'(1);
            end else begin
                row_q  <= row_q + CNT_W'(1);
                addr_q <= addr_q + ADDR_W'(WIN_W);
            end
        end
    end

    assign addr      = addr_q;
    assign col       = col_q;
    assign row_first = (row_q == '0);
    assign row_last  = (row_q == CNT_W'(WIN_H - 1));
    assign last      = row_last && (col_q == COL_W'(WIN_W - 1));

endmodule

// File: rtl/char_column_projector.sv
// Reads back a captured character window column by column and emits dark-pixel
// counts per column. Define CHAR_PROJ_TOTAL_EN for total/first/last outputs.
module char_column_projector
    import char_proj_pkg::*;
#(
    parameter int               WIN_W     = DEF_WIN_W,
    parameter int               WIN_H     = DEF_WIN_H,
    parameter int               BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [PIX_W-1:0] THRESH    = DEF_THRESH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   capture_we,
    char_column_projector_if.master bus,
    output logic                   busy,
    output logic                   done,
`ifdef CHAR_PROJ_TOTAL_EN
    output logic [TOT_W-1:0]       total_count,
    output logic [COL_W-1:0]       first_col,
    output logic [COL_W-1:0]       last_col,
`endif
    output state_t                 state_dbg
);

    state_t            state_q;
    state_t            state_d;

    logic              walk_start;
    logic              walk_adv;
    logic [ADDR_W-1:0] walk_addr;
    logic [COL_W-1:0]  walk_col;
    logic              walk_row_first;
    logic              walk_row_last;
    logic              walk_last;

    logic              ram_re;

    logic              re_d1;
    logic              first_d1;
    logic              last_d1;
    logic              pix_last_d1;
    logic [COL_W-1:0]  col_d1;

    logic [CNT_W-1:0]  acc_q;
    logic [CNT_W-1:0]  col_sum;
    logic              dark;
    logic              col_valid;

    char_proj_addr_walk #(
        .WIN_W     (WIN_W),
        .WIN_H     (WIN_H),
        .BASE_ADDR (BASE_ADDR)
    ) u_walk (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (walk_start),
        .advance   (walk_adv),
        .addr      (walk_addr),
        .col       (walk_col),
        .row_first (walk_row_first),
        .row_last  (walk_row_last),
        .last      (walk_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A capture is only recognised from IDLE, so capture_we activity while
    // scanning or flushing has no effect.
    always_comb begin
        state_d    = state_q;
        walk_start = 1'b0;
        walk_adv   = 1'b0;
        ram_re     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture_we) state_d = ARMED;
            end
            ARMED: begin
                if (!capture_we) begin
                    state_d    = SCAN;
                    walk_start = 1'b1;
                end
            end
            SCAN: begin
                ram_re   = 1'b1;
                walk_adv = 1'b1;
                busy     = 1'b1;
                if (walk_last) state_d = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (re_d1 && pix_last_d1) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Tags travel alongside the read so they line up with ram_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_d1       <= 1'b0;
            first_d1    <= 1'b0;
            last_d1     <= 1'b0;
            pix_last_d1 <= 1'b0;
            col_d1      <= '0;
        end else begin
            re_d1 <= ram_re;
            if (ram_re) begin
                first_d1    <= walk_row_first;
                last_d1     <= walk_row_last;
                pix_last_d1 <= walk_last;
                col_d1      <= walk_col;
            end
        end
    end

    assign dark      = re_d1 && (bus.ram_rdata < THRESH);
    assign col_sum   = first_d1 ? CNT_W'(dark) : sat_add1(acc_q, dark);
    assign col_valid = re_d1 && last_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (re_d1) begin
            acc_q <= col_sum;
        end
    end

    assign bus.ram_re    = ram_re;
    assign bus.ram_addr  = ram_re ? walk_addr : '0;
    assign bus.col_valid = col_valid;
    assign bus.col_idx   = col_d1;
    assign bus.col_count = col_valid ? col_sum : '0;
    assign state_dbg     = state_q;

`ifdef CHAR_PROJ_TOTAL_EN
    logic [TOT_W-1:0] total_q;
    logic [COL_W-1:0] first_q;
    logic [COL_W-1:0] last_q;

    // Cleared when a scan starts, so results hold from done until then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
            first_q <= NO_COL;
            last_q  <= '0;
        end else if (walk_start) begin
            total_q <= '0;
            first_q <= NO_COL;
            last_q  <= '0;
        end else if (col_valid && (col_sum != '0)) begin
            total_q <= total_q + TOT_W'(col_sum);
            if (first_q == NO_COL) first_q <= col_d1;
            last_q <= col_d1;
        end
    end

    assign total_count = total_q;
    assign first_col   = first_q;
    assign last_col    = last_q;
`endif

endmodule

// File: doc/char_column_projector.md
# char_column_projector

Downstream consumer of the character-window capture stage: once a 200×105 character window has been written into pixel RAM, this block reads it back column by column. It thresholds each 8-bit pixel, counts dark pixels per column and emits one count per column. The resulting vertical projection is used by the segmentation/recognition logic to locate character boundaries.

## Interface
- `WIN_W`, 200: window width in pixels (columns).
- `WIN_H`, 105: window height in pixels (rows).
- `BASE_ADDR`, 9001: RAM address of pixel (x=0, y=0); pixel (x,y) lives at `BASE_ADDR + y*WIN_W + x`.
- `THRESH`, 8'd128: a pixel is dark when `ram_rdata < THRESH`.
- `clk` in 1: single clock. Everything is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `capture_we` in 1: write-enable from the capture address stage; high while the window is being written.
- `ram_addr` out 16: read address to pixel RAM.
- `ram_re` out 1: read enable.
- `ram_rdata` in 8: pixel data, valid exactly 1 cycle after `ram_addr`/`ram_re`.
- `col_valid` out 1: one-cycle strobe; `col_idx`/`col_count` are valid.
- `col_idx` out 8: column index 0..WIN_W-1.
- `col_count` out 7: dark pixels in that column, 0..WIN_H.
- `busy` out 1: high from scan start until `done`.
- `done` out 1: one-cycle strobe after the last column is emitted.

## Operation
- FSM states and transitions:
  - IDLE → ARMED when `capture_we`=1.
  - ARMED → SCAN on the first cycle `capture_we`=0, which is the falling edge ending the capture.
  - SCAN: column-major walk.
    - Per column, issue WIN_H reads with y=0..WIN_H-1. Address starts at `BASE_ADDR + x` and adds WIN_W per row.
    - Next column start is the previous column start +1.
    - There are no gaps between reads, including across column boundaries.
  - SCAN → FLUSH after the read for (WIN_W-1, WIN_H-1) is issued.
  - FLUSH → DONE when that last pixel's data has been accumulated.
  - DONE (1 cycle, `done`=1) → IDLE.
- Accumulation:
  - A 1-cycle-delayed copy of `ram_re` plus first-row/last-row tags qualifies `ram_rdata`.
  - On a first-row tag the accumulator loads (dark?1:0); otherwise it adds.
  - On a last-row tag the final sum goes to `col_count` and `col_valid` pulses.
- Widths and addressing:
  - Address arithmetic is 16-bit unsigned. The maximum address is BASE_ADDR+WIN_W*WIN_H-1 = 30000, so there is no wrap.
  - The count saturates at its width; it cannot exceed WIN_H=105 < 128.
- `capture_we` toggling during SCAN/FLUSH is ignored. A new capture is recognised only from IDLE.
- `capture_we` already high at reset release: enter ARMED on the next cycle and wait for the fall.
- Reset mid-scan: all state clears immediately. No further `col_valid`/`done` strobes occur, and the block waits for a new capture.

## Timing
- Reset values: `ram_addr`=16'd0, `ram_re`=0, `col_valid`=0, `col_idx`=0, `col_count`=0, `busy`=0, `done`=0.
- The first `ram_re` is asserted in the cycle after ARMED sees `capture_we`=0.
- Column x: `col_valid` is asserted 1 cycle after its last read, i.e. cycle (x+1)*WIN_H + 1 counting the first read as cycle 1.
- `done` follows the final `col_valid` by 1 cycle.
- Total scan time: WIN_W*WIN_H + 2 cycles = 21002.
- `busy` rises with the first `ram_re` and falls in the cycle `done` is asserted.

## Configuration
- `CHAR_PROJ_TOTAL_EN` defined adds these outputs, all valid when `done`=1 and held until the next scan starts:
  - `total_count` [14:0]: sum of all column counts.
  - `first_col` [7:0]: lowest column with a nonzero count.
  - `last_col` [7:0]: highest column with a nonzero count.
  - If every count is 0: `first_col`=8'hFF and `last_col`=8'h00.
- `CHAR_PROJ_TOTAL_EN` undefined: these ports and their registers do not exist. All other behaviour is identical.

## Structure
- Shared package `char_proj_pkg` holds:
  - the FSM state enum (IDLE, ARMED, SCAN, FLUSH, DONE);
  - default WIN_W/WIN_H/BASE_ADDR constants;
  - derived widths: column index 8, count 7, total 15.
- One sub-module, `char_proj_addr_walk`, generates the column-major address sequence and the row/column-boundary tags. It has start/advance/last outputs.
- The top level contains the FSM, the read-latency alignment, thresholding and accumulation.

## Test plan
- All-white RAM (0xFF), one capture pulse → 200 `col_valid` strobes with `col_count`=0, `col_idx` 0..199 in order, `done` at cycle 21002.
- All-black RAM (0x00) → every `col_count`=105. With the macro on: `total_count`=21000, `first_col`=0, `last_col`=199.
- Dark only in column 37 rows 10..19, plus pixel (199,104) dark → col 37 count 10, col 199 count 1, all others 0. Checks the last pixel survives the FLUSH state.
- Pixel value boundary: rdata=127 counts as dark, rdata=128 does not (THRESH=128).
- Assert `rst_n`=0 at cycle 5000 of the scan → outputs return to reset values asynchronously, and no further strobes occur. A new `capture_we` pulse then runs a complete 200-column scan.
- `capture_we` toggled during SCAN → no restart, and the strobe count stays exactly 200.
